serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder. One sum bit per clock, LSB first.
//   Per-bit datapath: one full-adder cell built from two half_adder instances plus an OR.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_full_adder.sv | 43 ++++
 rtl/serial_adder.sv | 137 +++++++++++++
 tb/tb_serial_adder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and widths.
// The optional subtract feature is controlled by the SERIAL_ADDER_SUB_EN macro.
package serial_adder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half_adder cells; carry is the OR of both half carries.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder (
  input  logic A,
  input  logic B,
  input  logic cin,
  output logic C,
  output logic carry
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (
    .a (A),
    .b (B),
    .s (w_s1),
    .c (w_c1)
  );

  half_adder u_ha1 (
    .a (w_s1),
    .b (cin),
    .s (C),
    .c (w_c2)
  );

  assign carry = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one sum bit per clock with a carry flip-flop.
// Defining SERIAL_ADDER_SUB_EN adds a 'sub' port selecting (A-B) mod 2^WIDTH.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_areg;
  logic [WIDTH-1:0]   r_breg;
  logic [WIDTH-2:0]   r_sreg;
  logic               r_cff;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;

  logic               w_s;
  logic               w_c;
  logic [WIDTH-1:0]   w_shift;
  logic [WIDTH-1:0]   w_load_b;
  logic               w_load_c;

  full_adder u_fa (
    .A     (r_areg[0]),
    .B     (r_breg[0]),
    .cin   (r_cff),
    .C     (w_s),
    .carry (w_c)
  );

  // Subtraction is A + ~B + 1: invert B on load and preset the carry.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_load_b = sub ? ~B : B;
  assign w_load_c = sub;
`else
  assign w_load_b = B;
  assign w_load_c = 1'b0;
`endif

  // Only the upper WIDTH-1 bits need storing; the new bit enters at the MSB.
  assign w_shift = {w_s, r_sreg};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_areg  <= '0;
      r_breg  <= '0;
      r_sreg  <= '0;
      r_cff   <= 1'b0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_areg  <= A;
            r_breg  <= w_load_b;
            r_sreg  <= '0;
            r_cff   <= w_load_c;
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        S_RUN: begin
          r_areg <= {1'b0, r_areg[WIDTH-1:1]};
          r_breg <= {1'b0, r_breg[WIDTH-1:1]};
          r_sreg <= w_shift[WIDTH-1:1];
          r_cff  <= w_c;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= S_DONE;
            r_sum   <= w_shift;
            r_carry <= w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4) against an arithmetic reference model.
// Build with SERIAL_ADDER_SUB_EN defined to also exercise subtract mode.
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  always #5 clk = ~clk;

  // Present operands for one accepting edge; returns at the negedge after it.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
  endtask

  // Counts edges from the accepting edge (inclusive) until done is seen; bounded.
  task automatic wait_done(output int edges);
    edges = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      edges++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags got %b exp 100", {ready, busy, done});
    end
    checks++;
    if ({carry, sum} !== 5'd0) begin
      errors++;
      $display("FAIL reset_result got %0d exp 0", {carry, sum});
    end
  endtask

  task automatic test_basic;
    int edges;
    start_op(4'd3, 4'd5);
    checks++;
    if ({ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL run_flags got %b exp 01", {ready, busy});
    end
    wait_done(edges);
    checks++;
    if (edges !== W + 1) begin
      errors++;
      $display("FAIL latency got %0d exp %0d", edges, W + 1);
    end
    checks++;
    if ({carry, sum} !== 5'd8) begin
      errors++;
      $display("FAIL basic_3p5 got %0d exp 8", {carry, sum});
    end
    @(negedge clk);
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL after_done_flags got %b exp 100", {ready, busy, done});
    end
  endtask

  task automatic test_corners;
    logic [W-1:0] ta [3] = '{4'd15, 4'd9, 4'd0};
    logic [W-1:0] tb [3] = '{4'd1,  4'd9, 4'd0};
    logic [W:0]   exp;
    int edges;
    for (int i = 0; i < 3; i++) begin
      exp = {1'b0, ta[i]} + {1'b0, tb[i]};
      start_op(ta[i], tb[i]);
      wait_done(edges);
      checks++;
      if ({carry, sum} !== exp || edges !== W + 1) begin
        errors++;
        $display("FAIL corner_%0d got %0d/%0d edges exp %0d/%0d", i, {carry, sum}, edges, exp, W + 1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored;
    int ndone = 0;
    logic [W:0] seen = '0;
    start_op(4'd6, 4'd7);
    A = 4'd1;
    B = 4'd1;
    start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        seen = {carry, sum};
      end
      if (i == 4) start = 1'b0;
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_done_count got %0d exp 1", ndone);
    end
    checks++;
    if (seen !== 5'd13 || {carry, sum} !== 5'd13) begin
      errors++;
      $display("FAIL ignore_result got %0d exp 13", seen);
    end
  endtask

  task automatic test_mid_reset;
    int ndone = 0;
    int edges;
    start_op(4'd5, 4'd6);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ready, busy, done, carry, sum} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL abort_state got r%b b%b d%b res %0d exp r1 b0 d0 res 0", ready, busy, done, {carry, sum});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d exp 0", ndone);
    end
    start_op(4'd2, 4'd2);
    wait_done(edges);
    checks++;
    if ({carry, sum} !== 5'd4) begin
      errors++;
      $display("FAIL after_abort got %0d exp 4", {carry, sum});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int last = -1;
    int ndone = 0;
    int bad_gap = 0;
    int bad_sum = 0;
    @(negedge clk);
    A = 4'd1;
    B = 4'd2;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if ({carry, sum} !== 5'd3) bad_sum++;
        if (last >= 0 && i - last != W + 2) bad_gap++;
        last = i;
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (ndone < 6 || bad_gap !== 0) begin
      errors++;
      $display("FAIL b2b_cadence got %0d dones %0d bad gaps exp >=6 dones 0 bad", ndone, bad_gap);
    end
    checks++;
    if (bad_sum !== 0) begin
      errors++;
      $display("FAIL b2b_sum got %0d bad sums exp 0", bad_sum);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp;
    int edges;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      exp = {1'b0, a} + {1'b0, b};
      start_op(a, b);
      wait_done(edges);
      checks++;
      if ({carry, sum} !== exp || edges !== W + 1) begin
        errors++;
        $display("FAIL rand_add %0d+%0d got %0d edges %0d exp %0d edges %0d", a, b, {carry, sum}, edges, exp, W + 1);
      end
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] es;
    logic         ec;
    logic         m;
    int edges;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) begin a = 4'd5; b = 4'd3; m = 1'b1; end
      else if (i == 1) begin a = 4'd3; b = 4'd5; m = 1'b1; end
      else if (i == 2) begin a = 4'd3; b = 4'd5; m = 1'b0; end
      else begin a = W'($urandom); b = W'($urandom); m = 1'($urandom); end
      if (m) begin
        es = W'((int'(a) - int'(b) + 16) % 16);
        ec = (a >= b);
      end else begin
        es = W'((int'(a) + int'(b)) % 16);
        ec = (int'(a) + int'(b)) >= 16;
      end
      sub = m;
      start_op(a, b);
      sub = 1'($urandom);
      wait_done(edges);
      checks++;
      if (sum !== es || carry !== ec) begin
        errors++;
        $display("FAIL sub_mode m%0d %0d,%0d got %0d/%0d exp %0d/%0d", m, a, b, sum, carry, es, ec);
      end
      @(negedge clk);
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    test_random();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
